// File: rtl/cv32e40p_fetch_fifo_ft.sv
// cv32e40p_fetch_fifo_ft
// Instruction fetch buffer between the instruction memory response channel
// and the aligner. Holds fetched words in a DEPTH-entry circular FIFO, tracks
// in-flight bus transactions, and after a branch silently discards responses
// to requests issued before the branch.
//
// Optional feature macro: FETCH_FIFO_PARITY_EN
//   defined   -> even parity stored per entry, checked on pop (err_detected_o)
//   undefined -> no parity storage, err_detected_o tied low
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   trans_granted_i   fetch request granted this cycle
//   resp_valid_i      response word valid / resp_rdata_i response word
//   branch_i          branch/jump: flush FIFO, start discarding stale responses
//   fetch_valid_o     head entry valid / fetch_rdata_o head entry data
//   aligner_ready_i   aligner accepts head this cycle
//   fifo_cnt_o        occupied entries
//   space_o           fifo_cnt_o + outstanding_o < DEPTH
//   outstanding_o     in-flight transactions
//   err_detected_o    parity mismatch on popped word (pop cycle only)
module cv32e40p_fetch_fifo_ft #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 trans_granted_i,
  input  logic                                 resp_valid_i,
  input  logic [31:0]                          resp_rdata_i,
  input  logic                                 branch_i,
  output logic                                 fetch_valid_o,
  output logic [31:0]                          fetch_rdata_o,
  input  logic                                 aligner_ready_i,
  output logic [$clog2(DEPTH):0]               fifo_cnt_o,
  output logic                                 space_o,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 err_detected_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic {NORMAL, DRAIN} state_e;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
  state_e        state_q, state_d;
  logic          push, pop;

  assign fetch_valid_o = (cnt_q != '0);
  assign fetch_rdata_o = mem_q[rptr_q];
  assign fifo_cnt_o    = cnt_q;
  assign outstanding_o = outst_q;
  assign space_o       = (32'(cnt_q) + 32'(outst_q)) < DEPTH;

  always_comb begin
    // A pop in the branch cycle is ignored: the aligner restarts anyway.
    pop  = fetch_valid_o && aligner_ready_i && !branch_i;
    // A full FIFO still accepts a word when a pop frees an entry this cycle.
    push = resp_valid_i && !branch_i && (state_q == NORMAL) &&
           ((cnt_q < CW'(DEPTH)) || pop);

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    outst_d   = outst_q;

    if (branch_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      // Responses still owed for pre-branch requests, excluding one arriving now.
      if (resp_valid_i)
        discard_d = (outst_q == '0) ? '0 : outst_q - OW'(1);
      else
        discard_d = outst_q;
    end else begin
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push) wptr_d = wptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
      if (resp_valid_i && (state_q == DRAIN)) discard_d = discard_q - OW'(1);
    end

    if (trans_granted_i && !resp_valid_i) begin
      if (outst_q < OW'(MAX_OUTSTANDING)) outst_d = outst_q + OW'(1);
    end else if (resp_valid_i && !trans_granted_i) begin
      if (outst_q != '0) outst_d = outst_q - OW'(1);
    end

    state_d = (discard_d != '0) ? DRAIN : NORMAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      state_q   <= NORMAL;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      state_q   <= state_d;
    end
  end

  // Data array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= resp_rdata_i;
  end

`ifdef FETCH_FIFO_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && push) par_q[wptr_q] <= ^resp_rdata_i;
  end

  assign err_detected_o = pop && ((^fetch_rdata_o) != par_q[rptr_q]);
`else
  assign err_detected_o = 1'b0;
`endif

endmodule
